icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Miss-handling stage directly downstream of the instruction cache lookup.
- On an I-cache miss, it takes the missing PC and the victim way chosen by the lookup.
- It fetches the 16-byte line from memory as four 32-bit beats and assembles the 128-bit line.
- It then drives a one-cycle cache update (write enable, way, PC, line) back into the I-cache and signals completion to fetch.

Parameters:
- LINE_BEATS, 4, beats per cache line; only 4 is supported.
- WORD_W, 32, beat width in bits; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- miss_valid  in  1  fetch requests a refill; accepted when miss_ready=1
- miss_ready  out  1  block is idle and can accept a miss
- miss_pc  in  32  PC of the missing fetch; any offset allowed
- miss_way  in  1  victim way selected by the I-cache lookup
- cancel  in  1  fetch is no longer waiting for this refill (redirect)
- mem_rd_req  out  1  line read request to memory
- mem_rd_addr  out  32  line-aligned address, {pc[31:4],4'b0}
- mem_rd_gnt  in  1  memory accepted the request
- mem_rd_valid  in  1  one data beat is valid
- mem_rd_data  in  32  beat data, lowest address first
- ICache_Wena  out  1  one-cycle line write to the I-cache
- update_way  out  1  way to write
- update_pc  out  32  line-aligned PC of the line being written
- ICache_line  out  128  assembled line; beat k occupies bits [32k+31:32k]
- refill_done  out  1  one-cycle pulse: line installed and not cancelled
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, RECV, WRITE.
- Reset:
  - rst sampled at posedge forces IDLE, including mid-operation.
  - All outputs become 0 except miss_ready, which becomes 1.
  - The beat counter, cancelled flag and line buffer are cleared.
  - No partial line is ever written.
- IDLE:
  - miss_ready=1.
  - On miss_valid, latch {miss_pc[31:4],4'b0} and miss_way, clear the cancelled flag, and go to REQ.
  - miss_ready=0 from the next cycle.
- REQ:
  - mem_rd_req=1 and mem_rd_addr=latched address, both registered; first asserted in the cycle after acceptance.
  - mem_rd_req is held until mem_rd_gnt=1 and is never retracted.
  - On gnt, go to RECV; mem_rd_req=0 from the next cycle.
- RECV:
  - Each cycle with mem_rd_valid=1 stores mem_rd_data into slot beat_cnt, then increments the 2-bit counter.
  - The counter wraps 3->0 on the 4th beat, and the state moves to WRITE on that beat.
  - mem_rd_valid is ignored outside RECV. This includes the gnt cycle itself: beats are accepted only from the cycle after gnt.
  - Gaps between beats of any length are allowed.
- WRITE (exactly one cycle):
  - ICache_Wena=1, with update_way, update_pc and ICache_line valid in this cycle only.
  - refill_done=1 if the cancelled flag is 0.
  - Next state is IDLE; miss_ready=1 the following cycle.
  - A new miss is not accepted in the WRITE cycle.
- cancel:
  - In REQ or RECV it sets the cancelled flag.
  - The request/beat handshake still completes and the line is still installed: the data is correct, and no memory beats are orphaned.
  - Only refill_done is suppressed.
  - cancel in the WRITE cycle also suppresses refill_done.
  - cancel in IDLE is ignored, even when miss_valid=1 in the same cycle: the miss is accepted and the flag is cleared.
- Outputs update_way, update_pc and ICache_line hold their last value outside WRITE. Only ICache_Wena qualifies them.
- Minimum latency (gnt in the first REQ cycle, beats back-to-back from the next cycle):
  - accept at cycle 0; req at cycle 1; beats at cycles 2-5; WRITE at cycle 6.
- Throughput: one outstanding refill; no request pipelining.

Test Plan:
1. Basic refill:
   - Stimulus: miss_pc=0x1C000124, miss_way=1; gnt at the first req cycle; beats 0xA0,0xA1,0xA2,0xA3 back-to-back.
   - Response: mem_rd_addr=0x1C000120; ICache_Wena and refill_done at cycle 6; update_pc=0x1C000120, update_way=1; ICache_line={0xA3,0xA2,0xA1,0xA0} (beat 0 in the low word).
2. Delayed gnt and beat gaps:
   - Stimulus: gnt 5 cycles after req; 2 idle cycles between beats 1 and 2; valid also pulsed in the gnt cycle with 0xDEAD.
   - Response: req stays high for 5 cycles; 0xDEAD is not captured; line is correct; exactly one Wena.
3. Cancel mid-RECV:
   - Stimulus: cancel after beat 1.
   - Response: all 4 beats are consumed; Wena=1 with the correct line; refill_done stays 0; miss_ready=1 the next cycle.
4. Back-to-back misses:
   - Stimulus: miss_valid held high through the WRITE cycle with a second pc=0x00000040.
   - Response: second miss accepted only in the cycle after WRITE; second refill fully independent.
5. Reset mid-operation:
   - Stimulus: rst asserted after 2 beats.
   - Response: next cycle all outputs 0 and miss_ready=1; no Wena; a following refill at 0x2000 starts with beat_cnt=0 and completes correctly.
6. IDLE cancel with miss:
   - Stimulus: miss_valid=1 and cancel=1 in the same IDLE cycle.
   - Response: refill proceeds and refill_done=1.

Source files
------------

// File: rtl/icache_refill.sv
// I-cache miss refill: fetches one 16-byte line as four 32-bit beats, assembles it,
// and drives a single-cycle line write back into the I-cache.
module icache_refill #(
    parameter int LINE_BEATS = 4,
    parameter int WORD_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [31:0]                  miss_pc,
    input  logic                         miss_way,
    input  logic                         cancel,
    output logic                         mem_rd_req,
    output logic [31:0]                  mem_rd_addr,
    input  logic                         mem_rd_gnt,
    input  logic                         mem_rd_valid,
    input  logic [WORD_W-1:0]            mem_rd_data,
    output logic                         ICache_Wena,
    output logic                         update_way,
    output logic [31:0]                  update_pc,
    output logic [LINE_BEATS*WORD_W-1:0] ICache_line,
    output logic                         refill_done,
    output logic                         busy
);

    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        WRITE
    } state_t;

    state_t                                   state_q, state_d;
    logic [31:0]                              addr_q, addr_d;
    logic                                     way_q, way_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic                                     cancelled_q, cancelled_d;
    // Only the first LINE_BEATS-1 beats are buffered; the last beat goes straight to the output line.
    logic [LINE_BEATS-2:0][WORD_W-1:0]        buf_q, buf_d;
    logic                                     upd_way_q, upd_way_d;
    logic [31:0]                              upd_pc_q, upd_pc_d;
    logic [LINE_BEATS*WORD_W-1:0]             upd_line_q, upd_line_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            way_q       <= 1'b0;
            cnt_q       <= '0;
            cancelled_q <= 1'b0;
            buf_q       <= '0;
            upd_way_q   <= 1'b0;
            upd_pc_q    <= '0;
            upd_line_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            cnt_q       <= cnt_d;
            cancelled_q <= cancelled_d;
            buf_q       <= buf_d;
            upd_way_q   <= upd_way_d;
            upd_pc_q    <= upd_pc_d;
            upd_line_q  <= upd_line_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        way_d       = way_q;
        cnt_d       = cnt_q;
        cancelled_d = cancelled_q;
        buf_d       = buf_q;
        upd_way_d   = upd_way_q;
        upd_pc_d    = upd_pc_q;
        upd_line_d  = upd_line_q;
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    addr_d      = miss_pc & ~32'hF;
                    way_d       = miss_way;
                    cancelled_d = 1'b0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (cancel) cancelled_d = 1'b1;
                if (mem_rd_gnt) state_d = RECV;
            end
            RECV: begin
                if (cancel) cancelled_d = 1'b1;
                if (mem_rd_valid) begin
                    // The update outputs load only here, so they hold the previous line until the next install.
                    if (cnt_q == LAST_BEAT) begin
                        upd_line_d = {mem_rd_data, buf_q};
                        upd_pc_d   = addr_q;
                        upd_way_d  = way_q;
                        state_d    = WRITE;
                    end else begin
                        buf_d[cnt_q] = mem_rd_data;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign miss_ready  = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mem_rd_req  = (state_q == REQ);
    assign mem_rd_addr = addr_q;
    assign ICache_Wena = (state_q == WRITE);
    assign refill_done = (state_q == WRITE) && !cancelled_q && !cancel;
    assign update_way  = upd_way_q;
    assign update_pc   = upd_pc_q;
    assign ICache_line = upd_line_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed self-checking bench for icache_refill: each step drives inputs just after the
// clock edge and checks outputs with immediate assertions against hand-computed values.
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_pc;
    logic         miss_way;
    logic         cancel;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_gnt;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_data;
    logic         ICache_Wena;
    logic         update_way;
    logic [31:0]  update_pc;
    logic [127:0] ICache_line;
    logic         refill_done;
    logic         busy;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    icache_refill #(.LINE_BEATS(4), .WORD_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_pc      (miss_pc),
        .miss_way     (miss_way),
        .cancel       (cancel),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_gnt   (mem_rd_gnt),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .ICache_Wena  (ICache_Wena),
        .update_way   (update_way),
        .update_pc    (update_pc),
        .ICache_line  (ICache_line),
        .refill_done  (refill_done),
        .busy         (busy)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [31:0] pc, input logic way, input logic cn,
                                 input logic gnt, input logic vld, input logic [31:0] data);
        miss_valid   = mv;
        miss_pc      = pc;
        miss_way     = way;
        cancel       = cn;
        mem_rd_gnt   = gnt;
        mem_rd_valid = vld;
        mem_rd_data  = data;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [31:0] data);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, data);
        checkOutput("beat_no_wena", ICache_Wena, 1'b0);
        checkOutput("beat_no_req", mem_rd_req, 1'b0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        checkOutput("rst_ready", miss_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_req", mem_rd_req, 1'b0);
        checkOutput("rst_addr", mem_rd_addr, 32'h0);
        checkOutput("rst_wena", ICache_Wena, 1'b0);
        checkOutput("rst_done", refill_done, 1'b0);
        checkOutput("rst_line", ICache_line, 128'h0);
        rst = 1'b0;

        // Test 1: basic refill at minimum latency
        applyStimulus(1'b1, 32'h1C000124, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_ready", miss_ready, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_req", mem_rd_req, 1'b1);
        checkOutput("t1_addr", mem_rd_addr, 32'h1C000120);
        checkOutput("t1_ready_low", miss_ready, 1'b0);
        checkOutput("t1_busy", busy, 1'b1);
        step();
        for (int i = 0; i < 4; i++) beat(32'hA0 + 32'(i));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_wena", ICache_Wena, 1'b1);
        checkOutput("t1_done", refill_done, 1'b1);
        checkOutput("t1_upd_pc", update_pc, 32'h1C000120);
        checkOutput("t1_upd_way", update_way, 1'b1);
        checkOutput("t1_line", ICache_line, 128'h000000A3_000000A2_000000A1_000000A0);
        step();
        checkOutput("t1_wena_off", ICache_Wena, 1'b0);
        checkOutput("t1_done_off", refill_done, 1'b0);
        checkOutput("t1_ready_back", miss_ready, 1'b1);
        checkOutput("t1_line_hold", ICache_line, 128'h000000A3_000000A2_000000A1_000000A0);

        // Test 2: grant in the fifth request cycle, stray beat in the grant cycle, gap between beats
        applyStimulus(1'b1, 32'h00001238, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, (k == 4), (k == 4), (k == 4) ? 32'hDEAD : 32'h0);
            checkOutput("t2_req_hold", mem_rd_req, 1'b1);
            checkOutput("t2_addr", mem_rd_addr, 32'h00001230);
            step();
        end
        beat(32'hB0);
        beat(32'hB1);
        for (int g = 0; g < 2; g++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("t2_gap_wena", ICache_Wena, 1'b0);
            checkOutput("t2_gap_busy", busy, 1'b1);
            step();
        end
        beat(32'hB2);
        beat(32'hB3);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_wena", ICache_Wena, 1'b1);
        checkOutput("t2_done", refill_done, 1'b1);
        checkOutput("t2_upd_pc", update_pc, 32'h00001230);
        checkOutput("t2_upd_way", update_way, 1'b0);
        checkOutput("t2_line", ICache_line, 128'h000000B3_000000B2_000000B1_000000B0);
        step();
        checkOutput("t2_single_wena", ICache_Wena, 1'b0);

        // Test 3: cancel after beat 1
        applyStimulus(1'b1, 32'h00003010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        beat(32'hC0);
        beat(32'hC1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_cancel_busy", busy, 1'b1);
        step();
        beat(32'hC2);
        beat(32'hC3);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_wena", ICache_Wena, 1'b1);
        checkOutput("t3_done_suppressed", refill_done, 1'b0);
        checkOutput("t3_line", ICache_line, 128'h000000C3_000000C2_000000C1_000000C0);
        checkOutput("t3_upd_way", update_way, 1'b1);
        step();
        checkOutput("t3_ready", miss_ready, 1'b1);

        // Test 4: back-to-back misses, second held high through WRITE
        applyStimulus(1'b1, 32'h00005550, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        beat(32'hD0);
        beat(32'hD1);
        beat(32'hD2);
        applyStimulus(1'b1, 32'h00000040, 1'b1, 1'b0, 1'b0, 1'b1, 32'hD3);
        step();
        applyStimulus(1'b1, 32'h00000040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_write_ready", miss_ready, 1'b0);
        checkOutput("t4_wena1", ICache_Wena, 1'b1);
        checkOutput("t4_done1", refill_done, 1'b1);
        checkOutput("t4_upd_pc1", update_pc, 32'h00005550);
        checkOutput("t4_line1", ICache_line, 128'h000000D3_000000D2_000000D1_000000D0);
        step();
        applyStimulus(1'b1, 32'h00000040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_idle_ready", miss_ready, 1'b1);
        checkOutput("t4_idle_busy", busy, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_req2", mem_rd_req, 1'b1);
        checkOutput("t4_addr2", mem_rd_addr, 32'h00000040);
        step();
        for (int i = 0; i < 4; i++) beat(32'hE0 + 32'(i));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_wena2", ICache_Wena, 1'b1);
        checkOutput("t4_done2", refill_done, 1'b1);
        checkOutput("t4_upd_pc2", update_pc, 32'h00000040);
        checkOutput("t4_upd_way2", update_way, 1'b1);
        checkOutput("t4_line2", ICache_line, 128'h000000E3_000000E2_000000E1_000000E0);
        step();

        // Test 5: reset after two beats, then a clean refill at 0x2000
        applyStimulus(1'b1, 32'h00007770, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        beat(32'h55);
        beat(32'h66);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        checkOutput("t5_ready", miss_ready, 1'b1);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_req", mem_rd_req, 1'b0);
        checkOutput("t5_addr", mem_rd_addr, 32'h0);
        checkOutput("t5_wena", ICache_Wena, 1'b0);
        checkOutput("t5_done", refill_done, 1'b0);
        checkOutput("t5_upd_pc", update_pc, 32'h0);
        checkOutput("t5_upd_way", update_way, 1'b0);
        checkOutput("t5_line", ICache_line, 128'h0);
        applyStimulus(1'b1, 32'h00002000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_addr2", mem_rd_addr, 32'h00002000);
        step();
        for (int i = 0; i < 4; i++) beat(32'hF0 + 32'(i));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_wena2", ICache_Wena, 1'b1);
        checkOutput("t5_line2", ICache_line, 128'h000000F3_000000F2_000000F1_000000F0);
        checkOutput("t5_upd_pc2", update_pc, 32'h00002000);
        step();

        // Test 6: cancel together with miss_valid in IDLE is ignored
        applyStimulus(1'b1, 32'h00000080, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_req", mem_rd_req, 1'b1);
        step();
        for (int i = 0; i < 4; i++) beat(32'h10 + 32'(i));
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_wena", ICache_Wena, 1'b1);
        checkOutput("t6_done", refill_done, 1'b1);
        checkOutput("t6_line", ICache_line, 128'h00000013_00000012_00000011_00000010);
        step();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
